w_pattern_gen: RTL and testbench
================================

Name: w_pattern_gen

Overview:
- Serial stimulus transmitter that drives the `w` input of the sequence-detector FSMs (one-hot and binary).
- Captures a WIDTH-bit pattern and a bit count, then emits the pattern LSB-first, one bit per clock.
- Reports busy/done and its own binary state for LED display.
- Lets the detectors be exercised from switches with reproducible bit streams instead of hand-toggling `sw`.

Parameters:
- WIDTH, 8, pattern register width and maximum number of bits per burst.
- LW, $clog2(WIDTH+1) (4 for WIDTH=8), width of the length and bits_left fields.

Ports:
- clk  input  1  system clock (btnC at top level); all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset (btnU at top level).
- start  input  1  level request to begin a burst; sampled only in IDLE and DONE.
- rpt  input  1  repeat mode; when 1 at the last bit, the burst reloads and continues with no gap.
- pattern  input  WIDTH  bits to send; bit 0 is sent first.
- length  input  LW  number of bits to send, 1..WIDTH.
- w  output  1  serial bit stream to the detector `w` input.
- busy  output  1  high while in SEND.
- done  output  1  high while in DONE.
- state  output  2  binary state code for LEDs: IDLE=2'b00, SEND=2'b01, DONE=2'b10.
- bits_left  output  LW  bits remaining in the current burst, including the one on `w`; 0 outside SEND.

Behaviour:
- Reset (asynchronous, active-high, dominant over every other input):
  - state=IDLE, shift register=0, bits_left=0.
  - w=0, busy=0, done=0, all within the same cycle reset asserts.
- Length handling:
  - eff_len = length clamped to WIDTH; length > WIDTH is treated as WIDTH.
  - length==0: start is ignored and the block stays in IDLE with all outputs 0.
- IDLE:
  - On a clock edge with start=1 and eff_len>=1: shreg <= pattern, bits_left <= eff_len, state <= SEND.
  - Otherwise stay in IDLE.
- SEND:
  - w = shreg[0] (combinational from registers, valid for the whole cycle).
  - busy=1, done=0.
  - Each edge with bits_left>1: shreg <= shreg>>1 (zero fill), bits_left <= bits_left-1.
  - Edge with bits_left==1 and rpt=0: state <= DONE, bits_left <= 0, shreg <= 0.
  - Edge with bits_left==1 and rpt=1: reload shreg <= pattern and bits_left <= eff_len, sampling the current pattern/length; stay in SEND. There is no idle bit between bursts.
  - Reload with current length==0: go to DONE instead.
  - start, and changes on pattern/length, are ignored mid-burst; the captured values are used.
- Latency: the first bit appears on w in the cycle after the start edge; exactly eff_len cycles of busy=1 per burst.
- DONE:
  - w=0, busy=0, done=1.
  - Leave for IDLE only on an edge with start=0. A held button therefore cannot retrigger.
- Outside SEND: w=0 and bits_left=0.
- Reset mid-burst aborts immediately with no partial completion and no done pulse.
- State encoding is binary and matches the `state` port; unused code 2'b11 returns to IDLE on the next edge.

Decomposition:
- Shared package holds:
  - state localparams ST_IDLE / ST_SEND / ST_DONE;
  - the state width (2);
  - the LED index map for the extended top level (w_gen busy/done/state bits).
- One natural sub-module: w_shift_reg (WIDTH-bit load/shift-right register with zero fill, load-dominant over shift).
- FSM and counter live in w_pattern_gen.
- No other hierarchy.

Test Plan:
- Reset check: assert reset mid-cycle with start=1 -> w, busy, done, bits_left and state are all 0 immediately; they stay 0 while reset is held.
- Basic burst: pattern=8'b0000_1100, length=4, one start edge -> w = 0,0,1,1 over 4 cycles; busy high 4 cycles; then done=1 with state=2'b10; done holds until start=0, then state=2'b00.
- Full and clamped length: pattern=8'hA5, length=8 -> w = 1,0,1,0,0,1,0,1. Repeat with length=15 -> identical 8-bit stream, busy for 8 cycles.
- Zero length: length=0, start=1 for 5 cycles -> state stays 2'b00, busy=0, w=0.
- Repeat mode: pattern=8'b0000_0011, length=2, rpt=1 -> w = 1,1,1,1,... continuously, busy never drops. Drop rpt -> DONE after the current burst's last bit.
- Mid-burst disturbance:
  - change pattern and pulse start during SEND -> original stream unaffected;
  - assert reset at bit 3 of 6 -> immediate IDLE, done never asserts.
- End-to-end with detectors: drive detector w from this block with pattern=8'b0000_1111, length=8 -> detector z asserts on the cycles after the 2nd..4th consecutive zeros and ones, per the detector's state sequence.

Source files
------------

// File: rtl/w_pattern_gen_pkg.sv
// Shared definitions for the serial w-stimulus generator: state codes and the
// LED positions used by the extended top level.
package w_pattern_gen_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } w_state_e;

  // LED index map for the generator status on the extended top level.
  localparam int LED_WGEN_BUSY    = 15;
  localparam int LED_WGEN_DONE    = 14;
  localparam int LED_WGEN_STATE_H = 13;
  localparam int LED_WGEN_STATE_L = 12;

endpackage

// File: rtl/w_shift_reg.sv
// Load/shift-right register with zero fill; load takes priority over shift.
module w_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/w_pattern_gen.sv
// Serial stimulus transmitter: sends a captured pattern LSB-first on w, with
// optional gapless repeat, reporting busy/done and its binary state.
module w_pattern_gen
  import w_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rpt,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [ST_W-1:0]  state,
  output logic [LW-1:0]    bits_left
);

  w_state_e         state_q, state_d;
  logic [LW-1:0]    bits_left_q, bits_left_d;
  logic [LW-1:0]    eff_len;
  logic             load, shift;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] shreg;

  assign eff_len = (length > LW'(WIDTH)) ? LW'(WIDTH) : length;

  w_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (load_data),
    .q_o     (shreg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    load        = 1'b0;
    shift       = 1'b0;
    load_data   = pattern;
    case (state_q)
      ST_IDLE: begin
        bits_left_d = '0;
        if (start && (eff_len != '0)) begin
          load        = 1'b1;
          bits_left_d = eff_len;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bits_left_q > LW'(1)) begin
          shift       = 1'b1;
          bits_left_d = bits_left_q - LW'(1);
        end else if (rpt && (eff_len != '0)) begin
          load        = 1'b1;
          bits_left_d = eff_len;
        end else begin
          // Clear the register on exit so w and the shift state are clean.
          load        = 1'b1;
          load_data   = '0;
          bits_left_d = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        bits_left_d = '0;
        if (!start) state_d = ST_IDLE;
      end
      default: begin
        bits_left_d = '0;
        load        = 1'b1;
        load_data   = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign w         = busy & shreg[0];
  assign state     = state_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_w_pattern_gen.sv
// Directed self-checking bench for w_pattern_gen with hand-computed streams.
module tb_w_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rpt = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] length = 4'd0;
  logic       w, busy, done;
  logic [1:0] state;
  logic [3:0] bits_left;

  int total = 0;
  int bad   = 0;

  w_pattern_gen #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rpt       (rpt),
    .pattern   (pattern),
    .length    (length),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .state     (state),
    .bits_left (bits_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".w"}, w, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".state"}, state, 2'b00);
    check({tag, ".bits_left"}, bits_left, 0);
  endtask

  // One burst with start pulsed for one edge; exp holds the stream LSB-first.
  task automatic run_burst(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input int n, input logic [7:0] exp);
    pattern = pat;
    length  = len;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.w%0d", tag, i), w, exp[i]);
      check($sformatf("%s.busy%0d", tag, i), busy, 1);
      check($sformatf("%s.left%0d", tag, i), bits_left, n - i);
      tick();
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".state_done"}, state, 2'b10);
    tick();
    check({tag, ".state_idle"}, state, 2'b00);
  endtask

  initial begin
    // Reset held from time zero with start asserted.
    start   = 1'b1;
    pattern = 8'hFF;
    length  = 4'd8;
    #2;
    check_quiet("rst_t0");
    tick();
    check_quiet("rst_held");
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_quiet("idle");

    // Basic burst with start held throughout: done must hold until release.
    pattern = 8'b0000_1100;
    length  = 4'd4;
    start   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic.w%0d", i), w, (i >= 2) ? 1 : 0);
      check($sformatf("basic.busy%0d", i), busy, 1);
      check($sformatf("basic.left%0d", i), bits_left, 4 - i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("basic.done%0d", i), done, 1);
      check($sformatf("basic.state%0d", i), state, 2'b10);
      check($sformatf("basic.wdone%0d", i), w, 0);
      tick();
    end
    start = 1'b0;
    tick();
    check_quiet("basic.back");

    run_burst("full", 8'hA5, 4'd8, 8, 8'hA5);
    run_burst("clamp", 8'hA5, 4'd15, 8, 8'hA5);
    run_burst("ones_zeros", 8'b0000_1111, 4'd8, 8, 8'h0F);
    run_burst("single", 8'h01, 4'd1, 1, 8'h01);

    // Zero length: start ignored.
    length = 4'd0;
    start  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet($sformatf("zero%0d", i));
    end
    start = 1'b0;

    // Repeat mode: gapless 1,1,1,... with bits_left cycling 2,1.
    pattern = 8'b0000_0011;
    length  = 4'd2;
    rpt     = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rpt.w%0d", i), w, 1);
      check($sformatf("rpt.busy%0d", i), busy, 1);
      check($sformatf("rpt.left%0d", i), bits_left, (i % 2 == 0) ? 2 : 1);
      tick();
    end
    check("rpt.left_before_drop", bits_left, 2);
    rpt = 1'b0;
    tick();
    check("rpt.last_w", w, 1);
    check("rpt.last_left", bits_left, 1);
    tick();
    check("rpt.done", done, 1);
    check("rpt.state", state, 2'b10);
    tick();
    check("rpt.idle", state, 2'b00);

    // Pattern/length change and start pulse mid-burst must not disturb stream.
    pattern = 8'hA5;
    length  = 4'd8;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("dist.w%0d", i), w, (8'hA5 >> i) & 1);
      check($sformatf("dist.left%0d", i), bits_left, 8 - i);
      if (i == 1) begin
        pattern = 8'h00;
        length  = 4'd2;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("dist.done", done, 1);
    tick();
    check("dist.idle", state, 2'b00);

    // Reset at bit 3 of 6: immediate abort, no done afterward.
    pattern = 8'b0011_1111;
    length  = 4'd6;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort.pre_left", bits_left, 4);
    check("abort.pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    check_quiet("abort.now");
    tick();
    check_quiet("abort.held");
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("abort.nodone%0d", i), done, 0);
      check($sformatf("abort.idle%0d", i), state, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
